// File: rtl/hex_display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_pkg
// Brief    : Shared types and constants for the hex display scanner.
// Revision : 1.0
// ============================================================================
package hex_display_pkg;

    localparam int         DIGIT_W = 4;
    localparam logic [6:0] SEG_OFF = 7'h7f;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/hex_display_scanner_translator.sv
`default_nettype none
// ============================================================================
// Module   : HexDisplayTranslator
// Brief    : Hex nibble to active-low seven-segment pattern, gfedcba order.
// Revision : 1.0
// ============================================================================
module HexDisplayTranslator (
    input  logic [3:0] hex,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = 7'h7f;
        case (hex)
            4'h0: seg_n = 7'h40;
            4'h1: seg_n = 7'h79;
            4'h2: seg_n = 7'h24;
            4'h3: seg_n = 7'h30;
            4'h4: seg_n = 7'h19;
            4'h5: seg_n = 7'h12;
            4'h6: seg_n = 7'h02;
            4'h7: seg_n = 7'h78;
            4'h8: seg_n = 7'h00;
            4'h9: seg_n = 7'h10;
            4'hA: seg_n = 7'h08;
            4'hB: seg_n = 7'h03;
            4'hC: seg_n = 7'h46;
            4'hD: seg_n = 7'h21;
            4'hE: seg_n = 7'h06;
            4'hF: seg_n = 7'h0e;
            default: seg_n = 7'h7f;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/hex_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_scanner
// Brief    : Time-multiplexed hex display scanner with frame-aligned word
//            commit and blank gap between digit slots.
//            Optional: LEADING_ZERO_BLANK_EN suppresses leading zero digits.
// Revision : 1.0
// ============================================================================
module hex_display_scanner
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS      = 4,
    parameter int TICKS_PER_DIGIT = 50000,
    parameter int BLANK_TICKS     = 500
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] load_data,
    output logic [6:0]                    seg_n,
    output logic [NUM_DIGITS-1:0]         digit_sel_n,
    output logic                          frame_start
);

    localparam int CNT_W = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] c_blank_last = CNT_W'(BLANK_TICKS - 1);
    localparam logic [CNT_W-1:0] c_slot_last  = CNT_W'(TICKS_PER_DIGIT - 1);
    localparam logic [IDX_W-1:0] c_idx_last   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t                   r_state, w_state_next;
    logic [CNT_W-1:0]              r_cnt, w_cnt_next;
    logic [IDX_W-1:0]              r_idx, w_idx_next;

    logic                          r_pending;
    logic [DIGIT_W*NUM_DIGITS-1:0] r_pend_word;
    logic [DIGIT_W*NUM_DIGITS-1:0] r_active;
    logic [6:0]                    r_seg_n;
    logic [NUM_DIGITS-1:0]         r_sel_n;
    logic                          r_frame_start;

    logic                          w_frame_entry;
    logic [DIGIT_W-1:0]            w_digit;
    logic [6:0]                    w_seg_dec;
    logic                          w_digit_blank;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= BLANK;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 1'b1;
        w_idx_next   = r_idx;
        case (r_state)
            BLANK: begin
                if (r_cnt == c_blank_last) begin
                    w_state_next = SHOW;
                end
            end
            SHOW: begin
                if (r_cnt == c_slot_last) begin
                    w_state_next = BLANK;
                    w_cnt_next   = '0;
                    w_idx_next   = (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
                end
            end
            default: begin
                w_state_next = BLANK;
                w_cnt_next   = '0;
                w_idx_next   = '0;
            end
        endcase
    end

    // First cycle of digit 0's blank gap: the only point a new word may land.
    assign w_frame_entry = (r_state == BLANK) && (r_cnt == '0) && (r_idx == '0);

    assign w_digit = r_active[r_idx*DIGIT_W +: DIGIT_W];

    HexDisplayTranslator u_translator (
        .hex   (w_digit),
        .seg_n (w_seg_dec)
    );

`ifdef LEADING_ZERO_BLANK_EN
    function automatic logic [IDX_W-1:0] f_top_digit(
        input logic [DIGIT_W*NUM_DIGITS-1:0] word
    );
        logic [IDX_W-1:0] top;
        top = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (word[i*DIGIT_W +: DIGIT_W] != '0) begin
                top = IDX_W'(i);
            end
        end
        return top;
    endfunction

    assign w_digit_blank = (r_idx > f_top_digit(r_active));
`else
    assign w_digit_blank = 1'b0;
`endif

    // Selects and segments are registered together so a digit never lights
    // with the previous digit's pattern.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_seg_n       <= SEG_OFF;
            r_sel_n       <= '1;
            r_frame_start <= 1'b0;
            r_pending     <= 1'b0;
            r_pend_word   <= '0;
            r_active      <= '0;
        end else begin
            r_frame_start <= w_frame_entry;
            if (r_state == SHOW) begin
                r_sel_n <= ~(NUM_DIGITS'(1) << r_idx);
                r_seg_n <= w_digit_blank ? SEG_OFF : w_seg_dec;
            end else begin
                r_sel_n <= '1;
                r_seg_n <= SEG_OFF;
            end
            if (w_frame_entry && r_pending) begin
                r_active  <= r_pend_word;
                r_pending <= 1'b0;
            end else if (load_valid && !r_pending) begin
                r_pend_word <= load_data;
                r_pending   <= 1'b1;
            end
        end
    end

    assign load_ready  = !r_pending;
    assign seg_n       = r_seg_n;
    assign digit_sel_n = r_sel_n;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_hex_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_display_scanner
// Brief    : Cycle scoreboard for hex_display_scanner (8 ticks, 2 blank, 4 digits).
// Revision : 1.0
// ============================================================================
module tb_hex_display_scanner;

    localparam int ND    = 4;
    localparam int TPD   = 8;
    localparam int BT    = 2;
    localparam int FRAME = ND * TPD;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = '0;
    logic        load_ready;
    logic [6:0]  seg_n;
    logic [3:0]  digit_sel_n;
    logic        frame_start;

    hex_display_scanner #(
        .NUM_DIGITS      (ND),
        .TICKS_PER_DIGIT (TPD),
        .BLANK_TICKS     (BT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .seg_n       (seg_n),
        .digit_sel_n (digit_sel_n),
        .frame_start (frame_start)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] sel;
        logic       fs;
        logic       rdy;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    int          p_cnt = 0;
    logic        m_pending = 1'b0;
    logic [15:0] m_pword = '0;
    logic [15:0] m_active = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] dec(input logic [3:0] h);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e};
        return t[h];
    endfunction

    function automatic int top_digit(input logic [15:0] w);
        int top;
        top = 0;
        for (int i = 0; i < ND; i++) begin
            if (w[i*4 +: 4] != 4'h0) top = i;
        end
        return top;
    endfunction

    // Expected outputs after each edge, from the frame timeline since reset.
    always @(posedge clock) begin : p_model
        exp_t e;
        int   s;
        int   slot;
        int   pos;
        logic blank;
        if (reset) begin
            m_pending = 1'b0;
            m_active  = '0;
            p_cnt     = 0;
            e.seg = 7'h7f; e.sel = 4'hf; e.fs = 1'b0; e.rdy = 1'b1;
        end else begin
            s    = p_cnt % FRAME;
            slot = s / TPD;
            pos  = s % TPD;
            if (s == 0 && m_pending) begin
                m_active  = m_pword;
                m_pending = 1'b0;
            end else if (load_valid && !m_pending) begin
                m_pword   = load_data;
                m_pending = 1'b1;
            end
            p_cnt++;
`ifdef LEADING_ZERO_BLANK_EN
            blank = (slot > top_digit(m_active));
`else
            blank = 1'b0;
`endif
            if (pos < BT) begin
                e.sel = 4'hf;
                e.seg = 7'h7f;
            end else begin
                e.sel = ~(4'b0001 << slot);
                e.seg = blank ? 7'h7f : dec(m_active[slot*4 +: 4]);
            end
            e.fs  = (s == 0);
            e.rdy = !m_pending;
        end
        sb_q.push_back(e);
    end

    always @(negedge clock) begin : p_monitor
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("digit_sel_n", 32'(digit_sel_n), 32'(e.sel));
            check("seg_n", 32'(seg_n), 32'(e.seg));
            check("frame_start", 32'(frame_start), 32'(e.fs));
            check("load_ready", 32'(load_ready), 32'(e.rdy));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic load_word(input logic [15:0] w);
        load_valid = 1'b1;
        load_data  = w;
        @(negedge clock);
        load_valid = 1'b0;
    endtask

    task automatic wait_phase(input int ph);
        for (int i = 0; i < 2 * FRAME && (p_cnt % FRAME) != ph; i++) begin
            @(negedge clock);
        end
    endtask

    initial begin
        reset = 1'b1;
        cycles(3);
        reset = 1'b0;
        cycles(45);

        load_word(16'h1A3F);
        cycles(3);
        load_valid = 1'b1;
        load_data  = 16'hFFFF;
        cycles(70);
        load_valid = 1'b0;
        cycles(70);

        // Pending word lost to a reset during digit 2's lit period.
        wait_phase(4);
        load_word(16'h1234);
        wait_phase(21);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        cycles(70);

        load_word(16'h0050);
        cycles(70);
        load_word(16'h0000);
        cycles(70);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
Time-multiplexed controller that shares a single hex digit-to-segment decoder between NUM_DIGITS 4-bit values on a common-segment seven-segment display. It accepts new display words through a valid/ready handshake and applies them tear-free at frame boundaries. It sequences digit selects with an anti-ghosting blank gap. It sits between the clock/counter logic and the board's segment and digit pins.

Parameters:
NUM_DIGITS, 4, digits scanned; legal range 2..8
TICKS_PER_DIGIT, 50000, clock cycles per digit slot, including the blank gap; must be > BLANK_TICKS
BLANK_TICKS, 500, cycles at the start of each slot with all digits deselected; must be ≥ 1

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
load_valid  in  1  load_data is valid this cycle
load_ready  out  1  scanner can accept a new word
load_data  in  4*NUM_DIGITS  digit i is at bits [4i+3:4i]; digit 0 is rightmost
seg_n  out  7  active-low segments, gfedcba order, driven from the shared decoder
digit_sel_n  out  NUM_DIGITS  active-low one-hot digit enable
frame_start  out  1  one-cycle pulse when digit 0's slot begins

Behaviour:
- Reset: seg_n=7'h7f, digit_sel_n=all ones, frame_start=0, load_ready=1, pending empty, active register=0, digit index=0, state=BLANK, slot counter=0.
- FSM has two states:
  - BLANK: digit_sel_n all ones; seg_n=7'h7f. Slot counter counts 0..BLANK_TICKS-1, then the FSM goes to SHOW.
  - SHOW: digit_sel_n[idx]=0 and all other bits 1; seg_n=decode(active[idx]). Counter continues to TICKS_PER_DIGIT-1. Then idx increments, wrapping from NUM_DIGITS-1 to 0; the counter clears and the FSM goes to BLANK.
- Outputs are registered. seg_n and digit_sel_n change together, one cycle after the state change; they must never show a new digit with the old segments.
- Handshake:
  - A transfer occurs when load_valid and load_ready are both 1 on a rising edge. load_data is captured into the pending register and the pending flag is set.
  - load_ready = !pending.
  - load_data is ignored when load_ready=0.
- Frame commit: on entry to BLANK with idx=0 (including the first slot after reset exit), if pending is set:
  - active <= pending register;
  - pending flag clears, so load_ready=1 on the next cycle;
  - frame_start pulses high the same cycle.
- frame_start pulses on every idx=0 BLANK entry, whether or not a commit occurs.
- Simultaneous commit and new transfer is impossible, because load_ready=0 while pending is set. A new word is accepted no earlier than the cycle after a commit.
- At most one word is committed per frame. Values never change mid-frame.
- reset asserted mid-slot forces the reset values on the next edge. Any pending word is discarded.
- Frame period is NUM_DIGITS*TICKS_PER_DIGIT cycles.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: in SHOW, a digit whose index is above the highest nonzero committed digit outputs seg_n=7'h7f. Its digit_sel_n timing is unchanged. Digit 0 is always shown, so active=0 displays "0".
- Undefined: every digit is decoded as-is.

Decomposition:
- Package hex_display_pkg holds:
  - the scan_state_t enum {BLANK, SHOW};
  - SEG_OFF = 7'h7f;
  - the digit-width constant DIGIT_W = 4.
- Exactly one sub-module: the team's existing HexDisplayTranslator, instantiated once. Its input is muxed by idx and its output is registered into seg_n.
- The leading-zero mask is a local function, not a module.

Test Plan (TICKS_PER_DIGIT=8, BLANK_TICKS=2, NUM_DIGITS=4):
- Reset release, no load → digit_sel_n cycles 1110,1101,1011,0111 with each select low for 6 cycles and 2 all-ones cycles between slots; seg_n=7'b100_0000 while shown; frame_start every 32 cycles.
- Load 16'h1A3F mid-frame → load_ready falls the next cycle; the display is unchanged until the next frame_start; then digit0 seg_n=7'b000_1110, d1=7'b011_0000, d2=7'b000_1000, d3=7'b111_1001; load_ready rises the cycle after the commit.
- Second load_valid held while load_ready=0 with 16'hFFFF → ignored; still shows 1A3F; accepted only after the next commit.
- Reset asserted in the SHOW state of digit 2 → the next cycle shows all-ones digit_sel_n, seg_n=7'h7f, load_ready=1; the pending word is discarded.
- With LEADING_ZERO_BLANK_EN: load 16'h0050 → d3 blank, d2 blank, d1=7'b001_0010, d0=7'b100_0000; load 16'h0000 → only d0 shows 7'b100_0000.
